memory_unit: RTL and testbench

MEMORY_UNIT -- requirements
Module: memory_unit

---
 rtl/memory_unit_if.sv | 49 ++++
 rtl/memory_unit.sv | 108 ++++++++++
 tb/tb_memory_unit.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_unit_if.sv
// Host/CPU bus of the program memory unit.
// master = host and CPU side, slave = memory unit.
interface memory_unit_if #(
  parameter int WORD_SIZE     = 16,
  parameter int MEM_ADDR_SIZE = 8
);
  logic                     load_valid;
  logic [WORD_SIZE-1:0]     load_data;
  logic                     load_last;
  logic                     load_ready;
  logic                     execute;
  logic                     halted;
  logic [MEM_ADDR_SIZE-1:0] mem_address;
  logic [WORD_SIZE-1:0]     mem_write_data;
  logic                     mem_read;
  logic                     mem_write;
  logic [WORD_SIZE-1:0]     mem_read_data;
  logic                     dump_ready;
  logic                     dump_valid;
  logic                     dump_last;
  logic [WORD_SIZE-1:0]     dump_data;
  logic [1:0]               state;

  modport master (
    output load_valid, load_data, load_last,
    input  load_ready,
    input  execute,
    output halted,
    output mem_address, mem_write_data,
    output mem_read, mem_write,
    input  mem_read_data,
    output dump_ready,
    input  dump_valid, dump_last, dump_data,
    input  state
  );

  modport slave (
    input  load_valid, load_data, load_last,
    output load_ready,
    output execute,
    input  halted,
    input  mem_address, mem_write_data,
    input  mem_read, mem_write,
    output mem_read_data,
    input  dump_ready,
    output dump_valid, dump_last, dump_data,
    output state
  );
endinterface

// File: rtl/memory_unit.sv
// Program memory: host loads words, CPU runs
// against them, then the host dumps all words.
module memory_unit #(
  parameter int WORD_SIZE     = 16,
  parameter int MEM_ADDR_SIZE = 8
) (
  input  logic          clock,
  input  logic          reset,
  memory_unit_if.slave  bus
);
  localparam int DEPTH = 1 << MEM_ADDR_SIZE;
  localparam logic [MEM_ADDR_SIZE-1:0] PTR_MAX = '1;
  localparam logic [MEM_ADDR_SIZE-1:0] PTR_ONE =
    MEM_ADDR_SIZE'(1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_DUMP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                   r_state;
  logic [MEM_ADDR_SIZE-1:0] r_ptr;
  logic                     r_execute;
  logic [WORD_SIZE-1:0]     r_mem [DEPTH];

  logic                     w_in_load;
  logic                     w_in_run;
  logic                     w_in_dump;
  logic                     w_load_acc;
  logic                     w_run_wr;
  logic                     w_ptr_max;
  logic                     w_we;
  logic [MEM_ADDR_SIZE-1:0] w_waddr;
  logic [WORD_SIZE-1:0]     w_wdata;

  assign w_in_load  = (r_state == S_LOAD);
  assign w_in_run   = (r_state == S_RUN);
  assign w_in_dump  = (r_state == S_DUMP);
  assign w_load_acc = w_in_load && bus.load_valid;
  assign w_run_wr   = w_in_run && bus.mem_write;
  assign w_ptr_max  = (r_ptr == PTR_MAX);

  // Writes are blocked while reset is held so a
  // stray load_valid cannot corrupt the array.
  assign w_we    = reset && (w_load_acc || w_run_wr);
  assign w_waddr = w_load_acc ? r_ptr
                              : bus.mem_address;
  assign w_wdata = w_load_acc ? bus.load_data
                              : bus.mem_write_data;

  // Array write port; contents survive reset.
  always_ff @(posedge clock) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  // Phase sequencer with pointer and start pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_LOAD;
      r_ptr     <= '0;
      r_execute <= 1'b0;
    end else begin
      r_execute <= 1'b0;
      unique case (r_state)
        S_LOAD: begin
          if (bus.load_valid) begin
            if (bus.load_last || w_ptr_max) begin
              r_state   <= S_RUN;
              r_ptr     <= '0;
              r_execute <= 1'b1;
            end else begin
              r_ptr <= r_ptr + PTR_ONE;
            end
          end
        end
        S_RUN: begin
          if (bus.halted) r_state <= S_DUMP;
        end
        S_DUMP: begin
          if (bus.dump_ready) begin
            r_ptr <= r_ptr + PTR_ONE;
            if (w_ptr_max) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign bus.state      = r_state;
  assign bus.execute    = r_execute;
  assign bus.load_ready = w_in_load;
  assign bus.dump_valid = w_in_dump;
  assign bus.dump_last  = w_in_dump && w_ptr_max;
  assign bus.dump_data  = w_in_dump ? r_mem[r_ptr]
                                    : '0;

  // Zero-latency read: the CPU captures on the
  // same edge, and a same-cycle write lands after.
  assign bus.mem_read_data =
    (w_in_run && bus.mem_read)
      ? r_mem[bus.mem_address] : '0;
endmodule

// File: tb/tb_memory_unit.sv
// Scoreboard bench for memory_unit: stimulus
// queues expected reads/dumps, a monitor checks.
module tb_memory_unit;
  logic clk;
  logic rst_n;

  memory_unit_if #(
    .WORD_SIZE(16), .MEM_ADDR_SIZE(8)
  ) bus ();

  memory_unit #(
    .WORD_SIZE(16), .MEM_ADDR_SIZE(8)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [15:0] data;
    logic        last;
  } dump_t;

  int          checks = 0;
  int          errors = 0;
  int          exec_cnt = 0;
  logic [15:0] model [256];
  logic [15:0] rd_q [$];
  dump_t       dump_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs against queues.
  always @(negedge clk) begin
    if (rst_n && bus.execute) exec_cnt++;
    if (rst_n && bus.state == 2'd1 &&
        bus.mem_read) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got %0h",
                 bus.mem_read_data);
      end else begin
        logic [15:0] e;
        e = rd_q.pop_front();
        if (bus.mem_read_data !== e) begin
          errors++;
          $display("FAIL rd_data: got %0h exp %0h",
                   bus.mem_read_data, e);
        end
      end
    end
    if (rst_n && bus.dump_valid &&
        bus.dump_ready) begin
      checks++;
      if (dump_q.size() == 0) begin
        errors++;
        $display("FAIL dump_unexpected: got %0h",
                 bus.dump_data);
      end else begin
        dump_t e;
        e = dump_q.pop_front();
        if (bus.dump_data !== e.data ||
            bus.dump_last !== e.last) begin
          errors++;
          $display(
            "FAIL dump_word: got %0h/%0b exp %0h/%0b",
            bus.dump_data, bus.dump_last,
            e.data, e.last);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.load_valid     = 1'b0;
    bus.load_data      = '0;
    bus.load_last      = 1'b0;
    bus.halted         = 1'b0;
    bus.mem_address    = '0;
    bus.mem_write_data = '0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.dump_ready     = 1'b0;
  endtask

  task automatic push_dump(input int n);
    for (int i = 0; i < n; i++) begin
      dump_t d;
      d.data = model[i];
      d.last = (i == 255);
      dump_q.push_back(d);
    end
  endtask

  task automatic run_dump(input bit rnd);
    int cyc;
    cyc = 0;
    while (bus.state != 2'd3 && cyc < 3000) begin
      bus.dump_ready = rnd ? 1'($urandom_range(0, 1))
                           : 1'b1;
      step();
      cyc++;
    end
    bus.dump_ready = 1'b0;
    chk("dump_done_state", 32'(bus.state), 32'd3);
    chk("dump_q_empty", dump_q.size(), 0);
    chk("done_dump_valid", 32'(bus.dump_valid), 0);
    chk("done_dump_last", 32'(bus.dump_last), 0);
    chk("done_dump_data", 32'(bus.dump_data), 0);
    chk("done_load_ready", 32'(bus.load_ready), 0);
  endtask

  initial begin
    int e0;
    idle_bus();
    rst_n = 1'b0;
    bus.mem_read = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_load_ready", 32'(bus.load_ready), 1);
    chk("rst_execute", 32'(bus.execute), 0);
    chk("rst_dump_valid", 32'(bus.dump_valid), 0);
    chk("rst_dump_last", 32'(bus.dump_last), 0);
    chk("rst_dump_data", 32'(bus.dump_data), 0);
    chk("rst_rd_data", 32'(bus.mem_read_data), 0);
    bus.mem_read = 1'b0;
    rst_n = 1'b1;

    // 256 words without load_last, first edge on
    e0 = exec_cnt;
    bus.load_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.load_data = 16'hA000 + 16'(i);
      model[i] = 16'hA000 + 16'(i);
      step();
      if (i == 0)
        chk("stream_first_state",
            32'(bus.state), 0);
      if (i == 254)
        chk("stream_254_state",
            32'(bus.state), 0);
    end
    bus.load_valid = 1'b0;
    chk("stream_run_state", 32'(bus.state), 1);
    chk("stream_exec_hi", 32'(bus.execute), 1);
    chk("stream_load_ready", 32'(bus.load_ready), 0);
    step();
    chk("stream_exec_lo", 32'(bus.execute), 0);
    chk("stream_exec_cnt", exec_cnt - e0, 1);

    // reset mid-run
    rst_n = 1'b0;
    #1;
    chk("rst_run_state", 32'(bus.state), 0);
    step();
    rst_n = 1'b1;

    // three-word program
    e0 = exec_cnt;
    bus.load_valid = 1'b1;
    bus.load_data = 16'h1111;
    step();
    bus.load_data = 16'h2222;
    step();
    bus.load_data = 16'h3333;
    bus.load_last = 1'b1;
    step();
    model[0] = 16'h1111;
    model[1] = 16'h2222;
    model[2] = 16'h3333;
    bus.load_valid = 1'b0;
    bus.load_last = 1'b0;
    chk("prog_state", 32'(bus.state), 1);
    chk("prog_exec_hi", 32'(bus.execute), 1);
    bus.mem_read = 1'b1;
    bus.mem_address = 8'd1;
    rd_q.push_back(16'h2222);
    step();
    chk("prog_exec_lo", 32'(bus.execute), 0);

    // read-during-write returns pre-write data
    bus.mem_address = 8'd5;
    bus.mem_write = 1'b1;
    bus.mem_write_data = 16'hBEEF;
    rd_q.push_back(16'hA005);
    step();
    model[5] = 16'hBEEF;
    bus.mem_write = 1'b0;
    rd_q.push_back(16'hBEEF);
    step();
    bus.mem_read = 1'b0;
    #1;
    chk("rd_idle_zero", 32'(bus.mem_read_data), 0);
    chk("rd_q_empty", rd_q.size(), 0);

    // halt with same-cycle write
    bus.halted = 1'b1;
    bus.mem_write = 1'b1;
    bus.mem_address = 8'd7;
    bus.mem_write_data = 16'h00AA;
    step();
    model[7] = 16'h00AA;
    idle_bus();
    chk("halt_state", 32'(bus.state), 2);
    chk("dump_valid_hi", 32'(bus.dump_valid), 1);
    chk("exec_once", exec_cnt - e0, 1);
    push_dump(256);
    run_dump(1'b1);

    // writes ignored in DONE
    bus.mem_write = 1'b1;
    bus.mem_read = 1'b1;
    bus.mem_address = 8'd7;
    bus.mem_write_data = 16'hDEAD;
    #1;
    chk("done_rd_zero", 32'(bus.mem_read_data), 0);
    step();
    idle_bus();

    // reset from DONE; LOAD ignores mem_write/halted
    rst_n = 1'b0;
    #1;
    chk("rst_done_state", 32'(bus.state), 0);
    step();
    rst_n = 1'b1;
    bus.mem_write = 1'b1;
    bus.mem_address = 8'd8;
    bus.mem_write_data = 16'hDEAD;
    bus.halted = 1'b1;
    step();
    chk("load_halt_ign", 32'(bus.state), 0);
    idle_bus();
    bus.load_valid = 1'b1;
    bus.load_last = 1'b1;
    bus.load_data = 16'h5A5A;
    step();
    model[0] = 16'h5A5A;
    idle_bus();
    chk("one_word_state", 32'(bus.state), 1);
    bus.halted = 1'b1;
    step();
    bus.halted = 1'b0;
    chk("dump2_state", 32'(bus.state), 2);

    // reset mid-dump at ptr=10
    push_dump(10);
    bus.dump_ready = 1'b1;
    repeat (10) step();
    bus.dump_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_dump_state", 32'(bus.state), 0);
    chk("rst_dump_valid2", 32'(bus.dump_valid), 0);
    chk("mid_dump_q_empty", dump_q.size(), 0);
    step();
    rst_n = 1'b1;

    e0 = exec_cnt;
    bus.load_valid = 1'b1;
    bus.load_last = 1'b1;
    bus.load_data = 16'h0F0F;
    step();
    model[0] = 16'h0F0F;
    idle_bus();
    chk("reload_exec_hi", 32'(bus.execute), 1);
    step();
    step();
    chk("reload_exec_cnt", exec_cnt - e0, 1);
    bus.halted = 1'b1;
    step();
    bus.halted = 1'b0;
    push_dump(256);
    run_dump(1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
